writeback_slot_scheduler: RTL and testbench

Issue-stage block that consumes the single-cycle/multi-cycle classification produced by the latency decoder for the instruction selected for issue.
Tracks in-flight multi-cycle results in a shift-register reservation pipeline, and blocks issue on two conditions:
- a single-cycle result would reach writeback in the same cycle as an earlier multi-cycle result;
- a source register depends on a pending multi-cycle destination (RAW).
Sits between strand select and the execute stage.

---
 rtl/writeback_slot_scheduler_pkg.sv | 36 +++
 rtl/writeback_slot_scheduler_reg_hazard_match.sv | 29 ++
 rtl/writeback_slot_scheduler.sv | 110 +++++++++++
 tb/tb_writeback_slot_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/writeback_slot_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// writeback_slot_scheduler_pkg: shared widths, latency classes, reservation entry
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package writeback_slot_scheduler_pkg;

  localparam int REG_W                = 5;
  localparam int STRAND_COUNT_DEFAULT = 4;
  localparam int STRAND_W_MAX         = 8;

  function automatic int strand_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int STRAND_W = strand_w(STRAND_COUNT_DEFAULT);

  // Shared with the latency decoder and the execute result mux.
  typedef enum logic [1:0] {
    LAT_NONE   = 2'd0,
    LAT_SINGLE = 2'd1,
    LAT_MULTI  = 2'd2
  } lat_class_e;

  // Strand is stored zero-extended so the entry layout is fixed across configs.
  typedef struct packed {
    logic                    valid;
    logic [STRAND_W_MAX-1:0] strand;
    logic                    has_dest;
    logic [REG_W-1:0]        dest;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/writeback_slot_scheduler_reg_hazard_match.sv
// ---------------------------------------------------------------------------
// reg_hazard_match: RAW match of one reservation entry against an issuing op
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_hazard_match
  import writeback_slot_scheduler_pkg::*;
(
  input  wb_entry_t               entry_i,
  input  logic [STRAND_W_MAX-1:0] strand_i,
  input  logic                    uses_src_a_i,
  input  logic [REG_W-1:0]        src_a_reg_i,
  input  logic                    uses_src_b_i,
  input  logic [REG_W-1:0]        src_b_reg_i,
  output logic                    match_o
);

  logic src_hit;

  assign src_hit = (uses_src_a_i && (entry_i.dest == src_a_reg_i)) ||
                   (uses_src_b_i && (entry_i.dest == src_b_reg_i));

  assign match_o = entry_i.valid && entry_i.has_dest &&
                   (entry_i.strand == strand_i) && src_hit;

endmodule

`default_nettype wire

// File: rtl/writeback_slot_scheduler.sv
// ---------------------------------------------------------------------------
// writeback_slot_scheduler: multi-cycle reservation pipeline, slot-conflict and RAW issue stalls
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module writeback_slot_scheduler
  import writeback_slot_scheduler_pkg::*;
#(
  parameter  int STRAND_COUNT   = STRAND_COUNT_DEFAULT,
  parameter  int MULTI_LATENCY  = 4,
  parameter  int SINGLE_LATENCY = 1,
  localparam int STRAND_BITS    = strand_w(STRAND_COUNT),
  localparam int CNT_W          = $clog2(MULTI_LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_request_i,
  input  logic [STRAND_BITS-1:0]   issue_strand_i,
  input  logic                     single_cycle_i,
  input  logic                     multi_cycle_i,
  input  logic                     has_dest_i,
  input  logic [REG_W-1:0]         dest_reg_i,
  input  logic                     uses_src_a_i,
  input  logic                     uses_src_b_i,
  input  logic [REG_W-1:0]         src_a_reg_i,
  input  logic [REG_W-1:0]         src_b_reg_i,
  input  logic                     rollback_i,
  input  logic [STRAND_BITS-1:0]   rollback_strand_i,
  output logic                     issue_grant_o,
  output logic                     conflict_stall_o,
  output logic                     hazard_stall_o,
  output logic [MULTI_LATENCY-1:0] wb_slot_busy_o,
  output logic [CNT_W-1:0]         multi_inflight_o
);

  localparam int DELTA = MULTI_LATENCY - SINGLE_LATENCY;

  lat_class_e              cls;
  wb_entry_t               entry_q [MULTI_LATENCY];
  wb_entry_t               entry_d [MULTI_LATENCY];
  logic [STRAND_W_MAX-1:0] issue_strand_ext;
  logic [STRAND_W_MAX-1:0] rb_strand_ext;
  logic [MULTI_LATENCY-2:0] match;
  logic                    rb_self;

  assign issue_strand_ext = STRAND_W_MAX'(issue_strand_i);
  assign rb_strand_ext    = STRAND_W_MAX'(rollback_strand_i);

  always_comb begin
    cls = LAT_NONE;
    if (multi_cycle_i)       cls = LAT_MULTI;
    else if (single_cycle_i) cls = LAT_SINGLE;
  end

  // The oldest entry is in its writeback cycle and is covered by the bypass.
  for (genvar k = 0; k < MULTI_LATENCY - 1; k++) begin : g_haz
    reg_hazard_match u_match (
      .entry_i      (entry_q[k]),
      .strand_i     (issue_strand_ext),
      .uses_src_a_i (uses_src_a_i),
      .src_a_reg_i  (src_a_reg_i),
      .uses_src_b_i (uses_src_b_i),
      .src_b_reg_i  (src_b_reg_i),
      .match_o      (match[k])
    );
  end

  assign conflict_stall_o = issue_request_i && (cls == LAT_SINGLE) && entry_q[DELTA-1].valid;
  assign hazard_stall_o   = issue_request_i && (|match);
  assign rb_self          = rollback_i && (rollback_strand_i == issue_strand_i);
  assign issue_grant_o    = issue_request_i && !conflict_stall_o && !hazard_stall_o && !rb_self;

  always_comb begin
    for (int k = 0; k < MULTI_LATENCY; k++) entry_d[k] = '0;
    if (issue_grant_o && (cls == LAT_MULTI)) begin
      entry_d[0].valid    = 1'b1;
      entry_d[0].strand   = issue_strand_ext;
      entry_d[0].has_dest = has_dest_i;
      entry_d[0].dest     = dest_reg_i;
    end
    for (int k = 1; k < MULTI_LATENCY; k++) entry_d[k] = entry_q[k-1];
    // Squash is applied after the shift so an op moving into k+1 is cleared too.
    if (rollback_i) begin
      for (int k = 0; k < MULTI_LATENCY; k++) begin
        if (entry_d[k].strand == rb_strand_ext) entry_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MULTI_LATENCY; k++) entry_q[k] <= '0;
    end else begin
      for (int k = 0; k < MULTI_LATENCY; k++) entry_q[k] <= entry_d[k];
    end
  end

  always_comb begin
    wb_slot_busy_o   = '0;
    multi_inflight_o = '0;
    for (int k = 0; k < MULTI_LATENCY; k++) begin
      wb_slot_busy_o[k] = entry_q[k].valid;
      multi_inflight_o  = multi_inflight_o + CNT_W'(entry_q[k].valid);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_writeback_slot_scheduler: directed self-checking bench for writeback_slot_scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_writeback_slot_scheduler;

  logic       clk;
  logic       reset;
  logic       issue_request_i;
  logic [1:0] issue_strand_i;
  logic       single_cycle_i;
  logic       multi_cycle_i;
  logic       has_dest_i;
  logic [4:0] dest_reg_i;
  logic       uses_src_a_i;
  logic       uses_src_b_i;
  logic [4:0] src_a_reg_i;
  logic [4:0] src_b_reg_i;
  logic       rollback_i;
  logic [1:0] rollback_strand_i;
  logic       issue_grant_o;
  logic       conflict_stall_o;
  logic       hazard_stall_o;
  logic [3:0] wb_slot_busy_o;
  logic [2:0] multi_inflight_o;

  int n_chk = 0;
  int n_bad = 0;

  writeback_slot_scheduler #(
    .STRAND_COUNT   (4),
    .MULTI_LATENCY  (4),
    .SINGLE_LATENCY (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .issue_request_i   (issue_request_i),
    .issue_strand_i    (issue_strand_i),
    .single_cycle_i    (single_cycle_i),
    .multi_cycle_i     (multi_cycle_i),
    .has_dest_i        (has_dest_i),
    .dest_reg_i        (dest_reg_i),
    .uses_src_a_i      (uses_src_a_i),
    .uses_src_b_i      (uses_src_b_i),
    .src_a_reg_i       (src_a_reg_i),
    .src_b_reg_i       (src_b_reg_i),
    .rollback_i        (rollback_i),
    .rollback_strand_i (rollback_strand_i),
    .issue_grant_o     (issue_grant_o),
    .conflict_stall_o  (conflict_stall_o),
    .hazard_stall_o    (hazard_stall_o),
    .wb_slot_busy_o    (wb_slot_busy_o),
    .multi_inflight_o  (multi_inflight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic req, input logic [1:0] st, input logic sgl, input logic mul,
                     input logic hd, input logic [4:0] dst, input logic ua, input logic [4:0] sa);
    issue_request_i = req;
    issue_strand_i  = st;
    single_cycle_i  = sgl;
    multi_cycle_i   = mul;
    has_dest_i      = hd;
    dest_reg_i      = dst;
    uses_src_a_i    = ua;
    src_a_reg_i     = sa;
    uses_src_b_i    = 1'b0;
    src_b_reg_i     = 5'd0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rollback_i = 1'b0;
    rollback_strand_i = 2'd0;
    drv(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    // 1: reset state, grant follows request
    chk("rst_grant", 32'(issue_grant_o), 1);
    chk("rst_conf", 32'(conflict_stall_o), 0);
    chk("rst_haz", 32'(hazard_stall_o), 0);
    chk("rst_busy", 32'(wb_slot_busy_o), 0);
    chk("rst_cnt", 32'(multi_inflight_o), 0);
    reset = 1'b1;
    tick();
    chk("rel_busy", 32'(wb_slot_busy_o), 0);
    chk("rel_grant", 32'(issue_grant_o), 1);

    // 2: multi on strand 0, singles on strand 1 afterwards
    drv(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("t2_multi_grant", 32'(issue_grant_o), 1);
    tick();
    drv(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("t2_busy1", 32'(wb_slot_busy_o), 4'b0001);
    chk("t2_grant1", 32'(issue_grant_o), 1);
    tick();
    chk("t2_busy2", 32'(wb_slot_busy_o), 4'b0010);
    chk("t2_grant2", 32'(issue_grant_o), 1);
    chk("t2_cnt2", 32'(multi_inflight_o), 1);
    tick();
    chk("t2_busy3", 32'(wb_slot_busy_o), 4'b0100);
    chk("t2_conf3", 32'(conflict_stall_o), 1);
    chk("t2_grant3", 32'(issue_grant_o), 0);
    tick();
    chk("t2_busy4", 32'(wb_slot_busy_o), 4'b1000);
    chk("t2_conf4", 32'(conflict_stall_o), 0);
    chk("t2_grant4", 32'(issue_grant_o), 1);
    tick();
    chk("t2_busy5", 32'(wb_slot_busy_o), 4'b0000);

    // 3: RAW on strand 2, r7
    drv(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
    chk("t3_multi_grant", 32'(issue_grant_o), 1);
    tick();
    drv(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
    chk("t3_haz1", 32'(hazard_stall_o), 1);
    chk("t3_grant1", 32'(issue_grant_o), 0);
    uses_src_a_i = 1'b0; uses_src_b_i = 1'b1; src_b_reg_i = 5'd7; #1;
    chk("t3_haz1_srcb", 32'(hazard_stall_o), 1);
    uses_src_b_i = 1'b0; uses_src_a_i = 1'b1; src_a_reg_i = 5'd6; #1;
    chk("t3_haz1_r6", 32'(hazard_stall_o), 0);
    src_a_reg_i = 5'd7; #1;
    tick();
    chk("t3_haz2", 32'(hazard_stall_o), 1);
    issue_strand_i = 2'd1; #1;
    chk("t3_s1_haz", 32'(hazard_stall_o), 0);
    chk("t3_s1_grant", 32'(issue_grant_o), 1);
    issue_strand_i = 2'd2; #1;
    tick();
    chk("t3_haz3", 32'(hazard_stall_o), 1);
    chk("t3_conf3", 32'(conflict_stall_o), 1);
    chk("t3_grant3", 32'(issue_grant_o), 0);
    tick();
    chk("t3_haz4", 32'(hazard_stall_o), 0);
    chk("t3_grant4", 32'(issue_grant_o), 1);
    tick();
    chk("t3_busy5", 32'(wb_slot_busy_o), 0);

    // 4: rollback of strand 1
    drv(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    chk("t4_multi_grant", 32'(issue_grant_o), 1);
    tick();
    rollback_i = 1'b1; rollback_strand_i = 2'd1;
    drv(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("t4_busy1", 32'(wb_slot_busy_o), 4'b0001);
    chk("t4_other_grant", 32'(issue_grant_o), 1);
    issue_strand_i = 2'd1; #1;
    chk("t4_self_grant", 32'(issue_grant_o), 0);
    issue_strand_i = 2'd0; #1;
    tick();
    rollback_i = 1'b0;
    #1;
    chk("t4_busy2", 32'(wb_slot_busy_o), 0);
    chk("t4_cnt2", 32'(multi_inflight_o), 0);
    tick();
    chk("t4_conf3", 32'(conflict_stall_o), 0);
    chk("t4_grant3", 32'(issue_grant_o), 1);
    tick();

    // 5: four back-to-back multis on strand 3, no destination
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("t5_multi_grant", 32'(issue_grant_o), 1);
      if (i == 3) begin
        multi_cycle_i = 1'b0; single_cycle_i = 1'b1; #1;
        chk("t5_conf_t3", 32'(conflict_stall_o), 1);
        multi_cycle_i = 1'b1; single_cycle_i = 1'b0; #1;
      end
      tick();
    end
    drv(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("t5_busy4", 32'(wb_slot_busy_o), 4'b1111);
    chk("t5_cnt4", 32'(multi_inflight_o), 4);
    chk("t5_conf4", 32'(conflict_stall_o), 1);
    issue_strand_i = 2'd3; uses_src_a_i = 1'b1; #1;
    chk("t5_nodest_haz", 32'(hazard_stall_o), 0);
    issue_strand_i = 2'd0; uses_src_a_i = 1'b0; #1;
    tick();
    chk("t5_busy5", 32'(wb_slot_busy_o), 4'b1110);
    chk("t5_cnt5", 32'(multi_inflight_o), 3);
    chk("t5_conf5", 32'(conflict_stall_o), 1);
    chk("t5_grant5", 32'(issue_grant_o), 0);

    // 6: asynchronous reset mid-cycle with three entries valid
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy_async", 32'(wb_slot_busy_o), 0);
    chk("t6_cnt_async", 32'(multi_inflight_o), 0);
    chk("t6_conf_async", 32'(conflict_stall_o), 0);
    #1;
    reset = 1'b1;
    tick();
    chk("t6_busy_after", 32'(wb_slot_busy_o), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
